// File: rtl/pointwise_conv_mc_pkg.sv
// Shared defaults and fixed-point helpers for the multi-channel pointwise convolution.
package pointwise_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAC_BITS_DEF = 8;
  localparam int CIN_DEF       = 4;

  // Wide enough that CIN full-scale products can never overflow.
  function automatic int acc_width(input int data_w, input int cin);
    return 2*data_w + ((cin > 1) ? $clog2(cin) : 0);
  endfunction

  function automatic logic signed [63:0] round_const(input int frac);
    return (frac > 0) ? (64'sd1 <<< (frac-1)) : 64'sd0;
  endfunction

  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w-1)) - 64'sd1;
    lo = -(64'sd1 <<< (w-1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pointwise_conv_mc_if.sv
// Sample stream in, pixel stream out; the conv block is the slave side.
interface pointwise_conv_mc_if #(parameter int DATA_W = 16);
  logic                     pi_data_valid;
  logic signed [DATA_W-1:0] pi_data;
  logic                     po_data_valid;
  logic signed [DATA_W-1:0] po_data;
  logic                     frame_valid;

  modport slave  (input  pi_data_valid, pi_data,
                  output po_data_valid, po_data, frame_valid);
  modport master (output pi_data_valid, pi_data,
                  input  po_data_valid, po_data, frame_valid);
endinterface

// File: rtl/pw_round_sat.sv
// S3/S4: bias add, round half-up, saturate, optional ReLU (macro PW_RELU_EN).
module pw_round_sat
  import pointwise_pkg::*;
#(
  parameter int ACC_W     = 34,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic                     in_frame,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_frame
);
  localparam int SUM_W = ACC_W + 1;

  logic signed [SUM_W-1:0]  sum_c, rnd_q;
  logic signed [63:0]       sat_c;
  logic signed [DATA_W-1:0] res_c;
  logic                     vld_q, frm_q;

  // Bias is aligned to the product's 2*FRAC_BITS scale before rounding away FRAC_BITS.
  always_comb begin
    sum_c = (SUM_W'(acc) + (SUM_W'(bias) <<< FRAC_BITS)
             + SUM_W'(round_const(FRAC_BITS))) >>> FRAC_BITS;
  end

  always_comb begin
    sat_c = sat_to_w(64'(rnd_q), DATA_W);
    res_c = DATA_W'(sat_c);
`ifdef PW_RELU_EN
    if (res_c < 0) res_c = '0;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_q     <= 1'b0;
      frm_q     <= 1'b0;
      rnd_q     <= '0;
      out_valid <= 1'b0;
      out_frame <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      vld_q     <= 1'b0;
      frm_q     <= 1'b0;
      out_valid <= 1'b0;
      out_frame <= 1'b0;
    end else begin
      vld_q     <= in_valid;
      frm_q     <= in_valid & in_frame;
      if (in_valid) rnd_q <= sum_c;
      out_valid <= vld_q;
      out_frame <= vld_q & frm_q;
      if (vld_q) out_data <= res_c;
    end
  end

endmodule

// File: rtl/pointwise_conv_mc.sv
// Channel-serial 1x1 convolution: per-channel MAC across CIN samples, then round/saturate.
module pointwise_conv_mc
  import pointwise_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CIN       = CIN_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int IMG_W     = 9
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     clear,
  input  logic [IMG_W-1:0]         image_size,
  input  logic [CIN*DATA_W-1:0]    weight,
  input  logic signed [DATA_W-1:0] bias,
  pointwise_conv_mc_if.slave       io
);
  localparam int ACC_W = acc_width(DATA_W, CIN);
  localparam int CH_W  = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int PRD_W = 2*DATA_W;

  logic [CH_W-1:0]  ch;
  logic [IMG_W-1:0] col, row, size_q, size_eff;
  logic             frame_start, ch_last, col_last, row_last;

  // Size is taken live on the first sample of a frame, then held for the rest of it.
  always_comb begin
    frame_start = (ch == '0) && (col == '0) && (row == '0);
    size_eff    = frame_start ? image_size : size_q;
    ch_last     = (ch == CH_W'(CIN-1));
    col_last    = (col == size_eff - IMG_W'(1));
    row_last    = (row == size_eff - IMG_W'(1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ch     <= '0;
      col    <= '0;
      row    <= '0;
      size_q <= '0;
    end else if (clear) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (io.pi_data_valid) begin
      if (frame_start) size_q <= image_size;
      if (ch_last) begin
        ch <= '0;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + IMG_W'(1);
        end else begin
          col <= col + IMG_W'(1);
        end
      end else begin
        ch <= ch + CH_W'(1);
      end
    end
  end

  // vld_pipe[0]: S0 sample, [1]: S1 product, [2]: S2 pixel sum complete
  logic [2:0]               vld_pipe;
  logic signed [DATA_W-1:0] s0_data, w_sel;
  logic [CH_W-1:0]          s0_ch;
  logic                     s0_first, s0_last, s0_frame;
  logic signed [PRD_W-1:0]  s1_prod;
  logic                     s1_first, s1_last, s1_frame;
  logic signed [ACC_W-1:0]  acc;
  logic                     s2_frame;

  always_comb w_sel = weight[s0_ch*DATA_W +: DATA_W];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe <= '0;
      s0_data  <= '0;
      s0_ch    <= '0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
      s0_frame <= 1'b0;
      s1_prod  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_frame <= 1'b0;
      acc      <= '0;
      s2_frame <= 1'b0;
    end else if (clear) begin
      vld_pipe <= '0;
      acc      <= '0;
      s2_frame <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1] & s1_last, vld_pipe[0], io.pi_data_valid};
      if (io.pi_data_valid) begin
        s0_data  <= io.pi_data;
        s0_ch    <= ch;
        s0_first <= (ch == '0);
        s0_last  <= ch_last;
        s0_frame <= ch_last & col_last & row_last;
      end
      if (vld_pipe[0]) begin
        s1_prod  <= s0_data * w_sel;
        s1_first <= s0_first;
        s1_last  <= s0_last;
        s1_frame <= s0_frame;
      end
      if (vld_pipe[1]) acc <= s1_first ? ACC_W'(s1_prod) : acc + ACC_W'(s1_prod);
      s2_frame <= vld_pipe[1] & s1_last & s1_frame;
    end
  end

  pw_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (clear),
    .in_valid  (vld_pipe[2]),
    .in_frame  (s2_frame),
    .acc       (acc),
    .bias      (bias),
    .out_valid (io.po_data_valid),
    .out_data  (io.po_data),
    .out_frame (io.frame_valid)
  );

endmodule

// File: tb/tb_pointwise_conv_mc.sv
// Bench for pointwise_conv_mc: directed table, corner sequences and random pixels vs. a pixel-level model.
module tb_pointwise_conv_mc;
  import pointwise_pkg::*;

  localparam int DW  = 16;
  localparam int CIN = 4;
  localparam int FB  = 8;
  localparam int IW  = 9;

  logic                 sys_clk    = 1'b0;
  logic                 sys_rst_n  = 1'b0;
  logic                 clear      = 1'b0;
  logic [IW-1:0]        image_size = IW'(3);
  logic [CIN*DW-1:0]    weight     = '0;
  logic signed [DW-1:0] bias       = '0;

  pointwise_conv_mc_if #(.DATA_W(DW)) io();

  pointwise_conv_mc #(.DATA_W(DW), .CIN(CIN), .FRAC_BITS(FB), .IMG_W(IW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .clear      (clear),
    .image_size (image_size),
    .weight     (weight),
    .bias       (bias),
    .io         (io)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_frame  = 0;

  typedef struct { longint d; logic f; } exp_t;
  exp_t   expq[$];
  longint part[$];
  int     fr_pix  = 0;
  int     fr_size = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic longint wch(input int k);
    logic [CIN*DW-1:0]    wv;
    logic signed [DW-1:0] t;
    wv = weight;
    t  = wv[k*DW +: DW];
    return longint'(t);
  endfunction

  // A pixel is the dot product of its CIN samples with the weights, plus bias, in Q(FB).
  function automatic void model_accept(input logic signed [DW-1:0] d);
    longint sum, r;
    exp_t   e;
    if (part.size() == 0 && fr_pix == 0) fr_size = int'(image_size);
    part.push_back(longint'(d));
    if (part.size() == CIN) begin
      sum = longint'(bias) * (64'sd1 << FB);
      for (int k = 0; k < CIN; k++) sum += part[k] * wch(k);
      r = (sum + (64'sd1 << (FB-1))) >>> FB;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
`ifdef PW_RELU_EN
      if (r < 0) r = 0;
`endif
      fr_pix++;
      e.d = r;
      e.f = (fr_pix == fr_size*fr_size);
      if (e.f) fr_pix = 0;
      expq.push_back(e);
      part.delete();
    end
  endfunction

  function automatic void model_flush();
    part.delete();
    expq.delete();
    fr_pix = 0;
  endfunction

  always @(negedge sys_clk) begin
    if (sys_rst_n && io.po_data_valid) begin
      exp_t e;
      n_strobe++;
      if (io.frame_valid) n_frame++;
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_strobe: got po_data=%0d, expected no strobe (t=%0t)", io.po_data, $time);
      end else begin
        e = expq.pop_front();
        chk("po_data", longint'(io.po_data), e.d);
        chk("frame_valid", longint'(io.frame_valid), longint'(e.f));
      end
    end else if (sys_rst_n && io.frame_valid) begin
      checks++; errors++;
      $display("FAIL frame_without_strobe: got frame_valid=1, expected 0 (t=%0t)", $time);
    end
  end

  task automatic send(input logic signed [DW-1:0] d);
    io.pi_data_valid = 1'b1;
    io.pi_data       = d;
    model_accept(d);
    @(posedge sys_clk); #1;
    io.pi_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_flush();
    @(posedge sys_clk); #1;
    clear = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 30) begin @(posedge sys_clk); #1; n++; end
    if (expq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending results, expected 0", expq.size());
      expq.delete();
    end
    idle(2);
  endtask

  task automatic send_pixel_rand(input int gap_pct);
    for (int k = 0; k < CIN; k++) begin
      send(DW'($urandom));
      if (int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 3)));
    end
  endtask

  typedef struct {
    string                name;
    logic [CIN*DW-1:0]    w;
    logic [CIN*DW-1:0]    d;
    logic signed [DW-1:0] b;
    int                   gap_after;
    logic signed [DW-1:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, s0, f0;

    tbl[0] = '{"basic",   {4{16'h0100}}, {4{16'h0200}}, 16'sh0080, -1, 16'sh0880};
    tbl[1] = '{"gapped",  {4{16'h0100}}, {4{16'h0200}}, 16'sh0080,  1, 16'sh0880};
    tbl[2] = '{"sat_pos", {4{16'h7FFF}}, {4{16'h7FFF}}, 16'sh7FFF, -1, 16'sh7FFF};
`ifdef PW_RELU_EN
    tbl[3] = '{"sat_neg", {4{16'h7FFF}}, {4{16'h8000}}, 16'sh0000, -1, 16'sh0000};
`else
    tbl[3] = '{"sat_neg", {4{16'h7FFF}}, {4{16'h8000}}, 16'sh0000, -1, 16'sh8000};
`endif
    tbl[4] = '{"round",   {48'h0, 16'h0080}, {48'h0, 16'h0001}, 16'sh0000, -1, 16'sh0001};

    io.pi_data_valid = 1'b0;
    io.pi_data       = '0;
    idle(3);
    chk("reset_po_data_valid", longint'(io.po_data_valid), 0);
    chk("reset_po_data", longint'(io.po_data), 0);
    chk("reset_frame_valid", longint'(io.frame_valid), 0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    idle(2);

    // Directed table with latency measured from the closing sample's edge
    for (int i = 0; i < 5; i++) begin
      weight = tbl[i].w;
      bias   = tbl[i].b;
      for (int k = 0; k < CIN; k++) begin
        logic [CIN*DW-1:0] dv;
        dv = tbl[i].d;
        send(dv[k*DW +: DW]);
        if (k == tbl[i].gap_after) idle(3);
      end
      n = 0;
      do begin @(posedge sys_clk); #1; n++; end while (!io.po_data_valid && n < 10);
      chk({tbl[i].name, "_data"}, longint'(io.po_data), longint'(tbl[i].exp));
      chk({tbl[i].name, "_latency"}, n, 4);
      drain();
    end

    // Frame: 3x3 back-to-back pixels, then a second frame from row=col=0
    image_size = IW'(3);
    weight = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
    do_clear();
    s0 = n_strobe; f0 = n_frame;
    repeat (9) send_pixel_rand(0);
    drain();
    chk("frame_strobes", n_strobe - s0, 9);
    chk("frame_pulses", n_frame - f0, 1);
    repeat (9) send_pixel_rand(0);
    drain();
    chk("frame2_pulses", n_frame - f0, 2);

    // Clear after two samples: only the following full pixel emerges
    weight = {4{16'h0100}};
    bias   = 16'sh0080;
    s0 = n_strobe;
    send(16'sh1234); send(16'sh0777);
    do_clear();
    repeat (CIN) send(16'sh0200);
    n = 0;
    do begin @(posedge sys_clk); #1; n++; end while (!io.po_data_valid && n < 10);
    chk("clear_partial_data", longint'(io.po_data), 16'sh0880);
    drain();
    chk("clear_partial_strobes", n_strobe - s0, 1);

    // Clear right after a closed pixel squashes it in flight
    s0 = n_strobe;
    repeat (CIN) send(16'sh0100);
    do_clear();
    idle(8);
    chk("clear_inflight_strobes", n_strobe - s0, 0);
    chk("clear_holds_po_data", longint'(io.po_data), 16'sh0880);

    // Reset mid-pipeline
    repeat (CIN) send(16'sh0300);
    idle(1);
    sys_rst_n = 1'b0;
    model_flush();
    #1;
    chk("rst_po_data", longint'(io.po_data), 0);
    chk("rst_po_data_valid", longint'(io.po_data_valid), 0);
    chk("rst_frame_valid", longint'(io.frame_valid), 0);
    idle(2);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    idle(2);

    // Random pixels with gaps across varying frame sizes and value ranges
    for (int blk = 0; blk < 8; blk++) begin
      image_size = IW'($urandom_range(1, 4));
      if (blk % 2 == 0) begin
        weight = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
        bias   = DW'($urandom);
      end else begin
        for (int k = 0; k < CIN; k++) weight[k*DW +: DW] = DW'(int'($urandom_range(0, 1023)) - 512);
        bias = DW'(int'($urandom_range(0, 4095)) - 2048);
      end
      repeat (14) send_pixel_rand(25);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
